// File: rtl/sobel_frame_sequencer.sv
// Run controller for the sobel_hls kernel: frame-by-frame ap_start sequencing,
// AXIS beat/TLAST checking, no-progress watchdog and kernel flush on failure.
`timescale 1ns/1ps
module sobel_frame_sequencer #(
    parameter int BEATS_PER_FRAME = 4096,
    parameter int TIMEOUT_CYC     = 1024,
    parameter int FLUSH_CYC       = 4,
    parameter int FRAME_W         = 16
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FRAME_W-1:0] cmd_frames,
    input  logic               cmd_abort,
    output logic               k_ap_start,
    input  logic               k_ap_ready,
    input  logic               k_ap_done,
    output logic               k_rst_n,
    input  logic               s_tvalid,
    input  logic               s_tready,
    input  logic               m_tvalid,
    input  logic               m_tready,
    input  logic               m_tlast,
    output logic               busy,
    output logic               done_pulse,
    output logic [FRAME_W-1:0] frames_done,
    output logic               err_timeout,
    output logic               err_count,
    output logic               err_tlast
);

    localparam int BW = $clog2(BEATS_PER_FRAME + 2);
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam int FW = $clog2(FLUSH_CYC + 1);

    localparam logic [BW-1:0] BEAT_FULL = BW'(BEATS_PER_FRAME);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_PER_FRAME - 1);
    localparam logic [BW-1:0] BEAT_SAT  = BW'(BEATS_PER_FRAME + 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYC - 1);
    localparam logic [FW-1:0] FL_LAST   = FW'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE,
        S_FLUSH
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-1:0] remaining;
    logic [BW-1:0]      in_beats;
    logic [BW-1:0]      out_beats;
    logic [BW-1:0]      in_nxt;
    logic [BW-1:0]      out_nxt;
    logic [WW-1:0]      wd_cnt;
    logic [FW-1:0]      fl_cnt;
    logic               in_hit;
    logic               out_hit;
    logic               progress;
    logic               accept;
    logic               wd_exp;
    logic               last_frame;

    always_comb begin
        in_hit     = s_tvalid & s_tready;
        out_hit    = m_tvalid & m_tready;
        progress   = in_hit | out_hit | k_ap_done;
        accept     = (state == S_IDLE) & cmd_valid;
        in_nxt     = in_beats + BW'(in_hit && (in_beats != BEAT_SAT));
        out_nxt    = out_beats + BW'(out_hit && (out_beats != BEAT_SAT));
        wd_exp     = !progress && (wd_cnt == WD_LAST);
        last_frame = (remaining == FRAME_W'(1));
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // A done in the same cycle as abort or watchdog expiry is honoured first.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid && (cmd_frames != '0)) state_nxt = S_START;
            end
            S_START: begin
                if (cmd_abort)       state_nxt = S_FLUSH;
                else if (k_ap_ready) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (k_ap_done) begin
                    if (cmd_abort)       state_nxt = S_FLUSH;
                    else if (last_frame) state_nxt = S_DONE;
                    else                 state_nxt = S_START;
                end else if (cmd_abort || wd_exp) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            S_FLUSH: begin
                if (fl_cnt == FL_LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            k_ap_start  <= 1'b0;
            k_rst_n     <= 1'b1;
            done_pulse  <= 1'b0;
            frames_done <= '0;
            err_timeout <= 1'b0;
            err_count   <= 1'b0;
            err_tlast   <= 1'b0;
            remaining   <= '0;
            in_beats    <= '0;
            out_beats   <= '0;
            wd_cnt      <= '0;
            fl_cnt      <= '0;
        end else begin
            k_ap_start <= (state_nxt == S_START);
            k_rst_n    <= (state_nxt != S_FLUSH);
            done_pulse <= (state_nxt == S_DONE) ||
                          (accept && (cmd_frames == '0));
            fl_cnt     <= (state == S_FLUSH) ? fl_cnt + FW'(1) : '0;
            wd_cnt     <= '0;
            if (accept) begin
                frames_done <= '0;
                err_timeout <= 1'b0;
                err_count   <= 1'b0;
                err_tlast   <= 1'b0;
                remaining   <= cmd_frames;
            end
            if (state == S_START) begin
                in_beats  <= '0;
                out_beats <= '0;
            end
            if (state == S_RUN) begin
                in_beats  <= in_nxt;
                out_beats <= out_nxt;
                if (out_hit && (m_tlast != (out_beats == BEAT_LAST)))
                    err_tlast <= 1'b1;
                if (!progress && !wd_exp)
                    wd_cnt <= wd_cnt + WW'(1);
                if (wd_exp && !cmd_abort)
                    err_timeout <= 1'b1;
                if (k_ap_done) begin
                    if ((in_nxt != BEAT_FULL) || (out_nxt != BEAT_FULL))
                        err_count <= 1'b1;
                    frames_done <= frames_done + FRAME_W'(1);
                    remaining   <= remaining - FRAME_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Scoreboard bench for sobel_frame_sequencer with a simple kernel model
// driving the ap_* handshake and the tapped AXIS beats.
`timescale 1ns/1ps
module tb_sobel_frame_sequencer;

    localparam int BEATS = 4096;
    localparam int TMO   = 1024;
    localparam int FL    = 4;
    localparam int FW    = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [FW-1:0] cmd_frames = '0;
    logic          cmd_abort = 1'b0;
    logic          k_ap_start;
    logic          k_ap_ready = 1'b0;
    logic          k_ap_done = 1'b0;
    logic          k_rst_n;
    logic          s_tvalid = 1'b0;
    logic          s_tready = 1'b0;
    logic          m_tvalid = 1'b0;
    logic          m_tready = 1'b0;
    logic          m_tlast = 1'b0;
    logic          busy;
    logic          done_pulse;
    logic [FW-1:0] frames_done;
    logic          err_timeout;
    logic          err_count;
    logic          err_tlast;

    always #5 ap_clk = ~ap_clk;

    sobel_frame_sequencer #(
        .BEATS_PER_FRAME(BEATS),
        .TIMEOUT_CYC    (TMO),
        .FLUSH_CYC      (FL),
        .FRAME_W        (FW)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_frames (cmd_frames),
        .cmd_abort  (cmd_abort),
        .k_ap_start (k_ap_start),
        .k_ap_ready (k_ap_ready),
        .k_ap_done  (k_ap_done),
        .k_rst_n    (k_rst_n),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .done_pulse (done_pulse),
        .frames_done(frames_done),
        .err_timeout(err_timeout),
        .err_count  (err_count),
        .err_tlast  (err_tlast)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Passive monitors: handshakes, done pulses, flush length, timeout time.
    int   cyc = 0;
    int   n_hs = 0;
    int   n_done = 0;
    int   n_flush = 0;
    int   flush_len = 0;
    int   fl_cur = 0;
    int   tmo_cyc = 0;
    logic tmo_q = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(negedge ap_clk) begin
        if (k_ap_start && k_ap_ready) n_hs++;
        if (done_pulse) n_done++;
        if (!k_rst_n) begin
            fl_cur++;
        end else if (fl_cur != 0) begin
            flush_len = fl_cur;
            n_flush++;
            fl_cur = 0;
        end
        if (err_timeout && !tmo_q) tmo_cyc = cyc;
        tmo_q = err_timeout;
    end

    typedef struct {
        int frames;
        bit tmo;
        bit cnt;
        bit tl;
        int dones;
        int hs;
        int flushes;
    } exp_t;

    exp_t sb[$];
    int   hs0, done0, fl0;
    int   beat_cyc = 0;

    function automatic exp_t mk(input int f, input bit t, input bit c,
                                input bit l, input int d, input int h,
                                input int fl);
        exp_t e;
        e.frames = f; e.tmo = t; e.cnt = c; e.tl = l;
        e.dones = d; e.hs = h; e.flushes = fl;
        return e;
    endfunction

    task automatic send_cmd(input int n, input exp_t e);
        sb.push_back(e);
        hs0 = n_hs; done0 = n_done; fl0 = n_flush;
        @(posedge ap_clk); #1;
        cmd_valid  = 1'b1;
        cmd_frames = FW'(n);
        @(posedge ap_clk); #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic end_run(input string tag);
        exp_t e;
        int   k;
        k = 0;
        while (busy && k < 20000) begin
            @(negedge ap_clk);
            k++;
        end
        chk({tag, "_idle"}, 32'(busy), 0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        e = sb.pop_front();
        chk({tag, "_frames"}, 32'(frames_done), e.frames);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'(e.tmo));
        chk({tag, "_err_count"}, 32'(err_count), 32'(e.cnt));
        chk({tag, "_err_tlast"}, 32'(err_tlast), 32'(e.tl));
        chk({tag, "_done_pulses"}, n_done - done0, e.dones);
        chk({tag, "_starts"}, n_hs - hs0, e.hs);
        chk({tag, "_flushes"}, n_flush - fl0, e.flushes);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (!k_ap_start && k < 100) begin
            @(negedge ap_clk);
            k++;
        end
        chk({tag, "_start"}, 32'(k_ap_start), 1);
    endtask

    task automatic give_ready(input string tag);
        @(posedge ap_clk); #1;
        @(posedge ap_clk); #1;
        k_ap_ready = 1'b1;
        @(posedge ap_clk); #1;
        k_ap_ready = 1'b0;
        @(negedge ap_clk);
        chk({tag, "_start_drop"}, 32'(k_ap_start), 0);
    endtask

    task automatic drive_beats(input int n, input int tl_at);
        for (int i = 0; i < n; i++) begin
            @(posedge ap_clk); #1;
            s_tvalid = 1'b1; s_tready = 1'b1;
            m_tvalid = 1'b1; m_tready = 1'b1;
            m_tlast  = (i == tl_at);
            beat_cyc = cyc;
        end
        @(posedge ap_clk); #1;
        s_tvalid = 1'b0; s_tready = 1'b0;
        m_tvalid = 1'b0; m_tready = 1'b0;
        m_tlast  = 1'b0;
    endtask

    task automatic give_done(input bit ab);
        k_ap_done = 1'b1;
        cmd_abort = ab;
        @(posedge ap_clk); #1;
        k_ap_done = 1'b0;
        cmd_abort = 1'b0;
    endtask

    task automatic frame(input string tag, input int n, input int tl_at);
        wait_start(tag);
        give_ready(tag);
        drive_beats(n, tl_at);
        give_done(1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_k_ap_start", 32'(k_ap_start), 0);
        chk("rst_k_rst_n", 32'(k_rst_n), 1);
        chk("rst_outs", {done_pulse, err_timeout, err_count, err_tlast}, 0);
        chk("rst_frames", 32'(frames_done), 0);

        send_cmd(0, mk(0, 0, 0, 0, 1, 0, 0));
        @(negedge ap_clk);
        chk("zero_done_pulse", 32'(done_pulse), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_k_ap_start", 32'(k_ap_start), 0);
        end_run("zero");

        send_cmd(3, mk(3, 0, 0, 0, 1, 3, 0));
        repeat (3) frame("ok", BEATS, BEATS - 1);
        end_run("three");

        send_cmd(2, mk(2, 0, 1, 1, 1, 2, 0));
        frame("bad", BEATS - 1, BEATS - 3);
        frame("good", BEATS, BEATS - 1);
        end_run("err");

        send_cmd(1, mk(0, 1, 0, 0, 0, 1, 1));
        wait_start("tmo");
        give_ready("tmo");
        drive_beats(100, -1);
        end_run("tmo");
        chk("tmo_delay", tmo_cyc - beat_cyc, TMO + 1);
        chk("tmo_flush_len", flush_len, FL);

        send_cmd(4, mk(1, 0, 0, 0, 0, 1, 1));
        wait_start("ab");
        give_ready("ab");
        drive_beats(BEATS, BEATS - 1);
        give_done(1'b1);
        @(negedge ap_clk);
        chk("ab_k_ap_start", 32'(k_ap_start), 0);
        chk("ab_k_rst_n", 32'(k_rst_n), 0);
        chk("ab_frames_now", 32'(frames_done), 1);
        end_run("abort");
        chk("ab_flush_len", flush_len, FL);

        send_cmd(2, mk(0, 0, 0, 0, 0, 2, 0));
        frame("pre", BEATS - 1, BEATS - 3);
        wait_start("mid");
        give_ready("mid");
        drive_beats(10, -1);
        chk("mid_frames", 32'(frames_done), 1);
        chk("mid_err_tlast", 32'(err_tlast), 1);
        chk("mid_busy", 32'(busy), 1);
        #1 ap_rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_frames", 32'(frames_done), 0);
        chk("arst_errs", {err_timeout, err_count, err_tlast}, 0);
        chk("arst_k_rst_n", 32'(k_rst_n), 1);
        chk("arst_k_ap_start", 32'(k_ap_start), 0);
        @(posedge ap_clk);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        end_run("arst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
